// File: rtl/bp_cce_hybrid_mem_cmd_arbiter_pkg.sv
// Shared types and width helpers for the hybrid CCE memory command arbiter.
package bp_cce_hybrid_mem_cmd_arbiter_pkg;

    typedef enum int unsigned {
        e_bp_default_cfg = 0,
        e_bp_small_cfg   = 1
    } bp_params_e;

    localparam int dword_width_gp = 64;

    typedef enum logic {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } arb_state_e;

    // msg_type + subop + paddr + size + payload (lce id, way, state, prefetch)
    function automatic int mem_header_width(input bp_params_e cfg);
        int paddr_w;
        paddr_w = (cfg == e_bp_small_cfg) ? 32 : 40;
        return 4 + 4 + paddr_w + 3 + 8 + 3 + 4;
    endfunction

endpackage

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter_rr.sv
// Round-robin priority pick starting after the previous grantee; hold freezes the pick.
module bp_cce_hybrid_mem_cmd_arbiter_rr #(
    parameter int num_req_p = 2,
    parameter int id_w      = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] reqs,
    input  logic [id_w-1:0]      last,
    input  logic                 hold,
    output logic [id_w-1:0]      sel,
    output logic                 any
);

    int idx;

    always_comb begin
        sel = last;
        any = 1'b0;
        idx = 0;
        if (hold) begin
            any = reqs[last];
        end else begin
            // Scan from the farthest offset down so the nearest valid after 'last' wins.
            for (int k = num_req_p; k >= 1; k--) begin
                idx = (int'(last) + k) % num_req_p;
                if (reqs[idx]) begin
                    sel = id_w'(idx);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bp_cce_hybrid_mem_cmd_arbiter.sv
// Shares the CCE memory command stream among hybrid pipes, holding the grant for whole messages.
module bp_cce_hybrid_mem_cmd_arbiter
    import bp_cce_hybrid_mem_cmd_arbiter_pkg::*;
#(
    parameter bp_params_e bp_params_p              = e_bp_default_cfg,
    parameter int         num_req_p                = 2,
    parameter int         mem_data_width_p         = dword_width_gp,
    parameter int         cce_mem_msg_header_width_lp = mem_header_width(bp_params_p),
    localparam int        id_w                     = $clog2(num_req_p)
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic [num_req_p-1:0][cce_mem_msg_header_width_lp-1:0] req_header_i,
    input  logic [num_req_p-1:0][mem_data_width_p-1:0]        req_data_i,
    input  logic [num_req_p-1:0]                              req_v_i,
    input  logic [num_req_p-1:0]                              req_last_i,
    output logic [num_req_p-1:0]                              req_ready_and_o,
    output logic [cce_mem_msg_header_width_lp-1:0]            mem_cmd_header_o,
    output logic [mem_data_width_p-1:0]                       mem_cmd_data_o,
    output logic                                              mem_cmd_v_o,
    output logic                                              mem_cmd_last_o,
    input  logic                                              mem_cmd_ready_and_i,
    output logic [id_w-1:0]                                   grant_id_o,
    output logic                                              locked_o,
    output logic                                              empty_o
);

    arb_state_e      state_r;
    logic [id_w-1:0] grant_r;
    logic [id_w-1:0] sel;
    logic            any;
    logic            fire;

    bp_cce_hybrid_mem_cmd_arbiter_rr #(.num_req_p(num_req_p), .id_w(id_w)) rr (
        .reqs (req_v_i),
        .last (grant_r),
        .hold (state_r == e_locked),
        .sel  (sel),
        .any  (any)
    );

    // Handshake outputs are gated by reset directly so they drop without a clock edge.
    assign mem_cmd_header_o = req_header_i[sel];
    assign mem_cmd_data_o   = req_data_i[sel];
    assign mem_cmd_v_o      = reset_n_i & any;
    assign mem_cmd_last_o   = reset_n_i & req_last_i[sel];
    assign fire             = mem_cmd_v_o & mem_cmd_ready_and_i;

    always_comb begin
        req_ready_and_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            req_ready_and_o[i] = reset_n_i & mem_cmd_ready_and_i & (id_w'(i) == sel)
                               & ((state_r == e_locked) | req_v_i[i]);
        end
    end

    assign grant_id_o = reset_n_i ? sel : id_w'(num_req_p - 1);
    assign locked_o   = (state_r == e_locked);
    assign empty_o    = ~locked_o & ~|req_v_i;

    // A presented but unaccepted first beat also locks, keeping the header stable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            grant_r <= id_w'(num_req_p - 1);
        end else begin
            case (state_r)
                e_idle: begin
                    if (mem_cmd_v_o) begin
                        grant_r <= sel;
                        if (!(fire && mem_cmd_last_o)) state_r <= e_locked;
                    end
                end
                e_locked: begin
                    if (fire && mem_cmd_last_o) state_r <= e_idle;
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule
